// File: rtl/pipe_ctrl_unit_if.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_unit_if
// Bundles the ID-stage inputs and the control outputs of pipe_ctrl_unit.
//   master : the pipeline/testbench side (drives the ID fields, reads control)
//   slave  : pipe_ctrl_unit itself
// Signals:
//   valid_i, op_i, rs_i, rt_i, eq_i, stall_i   ID-stage instruction + freeze
//   branch_o, jump_o, flush_o, hz_stall_o      combinational steering
//   ex_ctrl_o, mem_ctrl_o, wb_ctrl_o           staged control word slices
//   illegal_o, ill_cnt_o                       illegal-opcode status
//   stall_cnt_o, flush_cnt_o                   only with CTRL_PERF_CNT_EN
// Handshake: there is no back-pressure. When valid_i is high, the ID
// instruction is taken on a rising edge where stall_i and hz_stall_o are both
// low. Otherwise the same instruction must be presented again.
// ---------------------------------------------------------------------------
interface pipe_ctrl_unit_if #(
    parameter int REG_ADDR_W = 5,
    parameter int ILL_CNT_W  = 8
`ifdef CTRL_PERF_CNT_EN
    ,
    parameter int PERF_CNT_W = 16
`endif
);
    logic                  valid_i;
    logic [5:0]            op_i;
    logic [REG_ADDR_W-1:0] rs_i;
    logic [REG_ADDR_W-1:0] rt_i;
    logic                  eq_i;
    logic                  stall_i;
    logic                  branch_o;
    logic                  jump_o;
    logic                  flush_o;
    logic                  hz_stall_o;
    logic [3:0]            ex_ctrl_o;
    logic [1:0]            mem_ctrl_o;
    logic [1:0]            wb_ctrl_o;
    logic                  illegal_o;
    logic [ILL_CNT_W-1:0]  ill_cnt_o;
`ifdef CTRL_PERF_CNT_EN
    logic [PERF_CNT_W-1:0] stall_cnt_o;
    logic [PERF_CNT_W-1:0] flush_cnt_o;
`endif

    modport master (
        output valid_i, op_i, rs_i, rt_i, eq_i, stall_i,
        input  branch_o, jump_o, flush_o, hz_stall_o,
        input  ex_ctrl_o, mem_ctrl_o, wb_ctrl_o, illegal_o, ill_cnt_o
`ifdef CTRL_PERF_CNT_EN
        ,
        input  stall_cnt_o, flush_cnt_o
`endif
    );

    modport slave (
        input  valid_i, op_i, rs_i, rt_i, eq_i, stall_i,
        output branch_o, jump_o, flush_o, hz_stall_o,
        output ex_ctrl_o, mem_ctrl_o, wb_ctrl_o, illegal_o, ill_cnt_o
`ifdef CTRL_PERF_CNT_EN
        ,
        output stall_cnt_o, flush_cnt_o
`endif
    );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_unit
// Decodes the ID-stage opcode of a 5-stage MIPS pipeline into branch/jump/
// flush steering and an 8-bit control word. That word is then carried through
// the ID/EX, EX/MEM and MEM/WB control registers. The unit also detects
// load-use hazards, inserts bubbles and counts illegal opcodes.
// Ports:
//   clk_i    clock, all state updates on the rising edge
//   rst_n_i  synchronous active-low reset
//   bus      pipe_ctrl_unit_if.slave (ID fields in, control out)
// Control word: [0] ALUSrc [2:1] ALUOp [3] RegDst [4] MemRead [5] MemWrite
//               [6] RegWrite [7] MemtoReg (1 = ALU result)
// Optional feature macro: CTRL_PERF_CNT_EN adds saturating stall/flush
// cycle counters (stall_cnt_o, flush_cnt_o on the interface).
// ---------------------------------------------------------------------------
module pipe_ctrl_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int ILL_CNT_W  = 8,
    parameter int PERF_CNT_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    pipe_ctrl_unit_if.slave   bus
);
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_NOP  = 6'b111111;

    if ((REG_ADDR_W < 1) || (ILL_CNT_W < 1) || (PERF_CNT_W < 1)) begin : g_bad_param
        $error("pipe_ctrl_unit: parameter widths must be positive");
    end

    // Stage registers. Each stage keeps only the bits that are still needed
    // downstream: EX/MEM keeps word[7:4] and MEM/WB keeps word[7:6].
    logic [7:0]            idex_q,    idex_d;
    logic [REG_ADDR_W-1:0] idex_rt_q, idex_rt_d;
    logic [3:0]            exmem_q,   exmem_d;
    logic [1:0]            memwb_q,   memwb_d;
    logic                  illegal_q, illegal_d;
    logic [ILL_CNT_W-1:0]  ill_cnt_q, ill_cnt_d;
`ifdef CTRL_PERF_CNT_EN
    logic [PERF_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [PERF_CNT_W-1:0] flush_cnt_q, flush_cnt_d;
`endif

    logic [7:0] dec_word;
    logic       dec_illegal;
    logic       dec_uses_rt;
    logic       hz_stall;
    logic       branch;
    logic       jump;
    logic       bubble;
    logic       accept;

    // Opcode decode
    always_comb begin
        dec_word    = 8'h00;
        dec_illegal = 1'b0;
        dec_uses_rt = 1'b0;
        unique case (bus.op_i)
            OP_R:    begin dec_word = 8'hCE; dec_uses_rt = 1'b1; end
            OP_ADDI: dec_word = 8'hC1;
            OP_LW:   dec_word = 8'h51;
            OP_SW:   begin dec_word = 8'h21; dec_uses_rt = 1'b1; end
            OP_BEQ:  dec_uses_rt = 1'b1;
            OP_J:    dec_word = 8'h00;
            OP_NOP:  dec_word = 8'h00;
            default: dec_illegal = 1'b1;
        endcase
    end

    // Load-use hazard. A load in EX writes idex_rt, and a zero specifier never
    // creates a dependency because $0 is hard-wired.
    always_comb begin
        hz_stall = bus.valid_i & idex_q[4] & (idex_rt_q != '0) &
                   ((idex_rt_q == bus.rs_i) | ((idex_rt_q == bus.rt_i) & dec_uses_rt));
        branch   = bus.valid_i & (bus.op_i == OP_BEQ) & bus.eq_i & ~hz_stall;
        jump     = bus.valid_i & (bus.op_i == OP_J) & ~hz_stall;
        bubble   = ~bus.valid_i | hz_stall | dec_illegal;
        accept   = bus.valid_i & ~bus.stall_i & ~hz_stall;
    end

    // Next-state logic. stall_i freezes the stage registers and the counters.
    always_comb begin
        idex_d    = idex_q;
        idex_rt_d = idex_rt_q;
        exmem_d   = exmem_q;
        memwb_d   = memwb_q;
        illegal_d = illegal_q;
        ill_cnt_d = ill_cnt_q;
`ifdef CTRL_PERF_CNT_EN
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
`endif
        if (!bus.stall_i) begin
            memwb_d   = exmem_q[3:2];
            exmem_d   = idex_q[7:4];
            idex_d    = bubble ? 8'h00 : dec_word;
            idex_rt_d = bubble ? '0 : bus.rt_i;
`ifdef CTRL_PERF_CNT_EN
            if (hz_stall && (stall_cnt_q != {PERF_CNT_W{1'b1}}))
                stall_cnt_d = stall_cnt_q + 1'b1;
            if ((branch || jump) && (flush_cnt_q != {PERF_CNT_W{1'b1}}))
                flush_cnt_d = flush_cnt_q + 1'b1;
`endif
        end
        if (accept && dec_illegal) begin
            illegal_d = 1'b1;
            if (ill_cnt_q != {ILL_CNT_W{1'b1}})
                ill_cnt_d = ill_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            idex_q    <= '0;
            idex_rt_q <= '0;
            exmem_q   <= '0;
            memwb_q   <= '0;
            illegal_q <= 1'b0;
            ill_cnt_q <= '0;
`ifdef CTRL_PERF_CNT_EN
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
`endif
        end else begin
            idex_q    <= idex_d;
            idex_rt_q <= idex_rt_d;
            exmem_q   <= exmem_d;
            memwb_q   <= memwb_d;
            illegal_q <= illegal_d;
            ill_cnt_q <= ill_cnt_d;
`ifdef CTRL_PERF_CNT_EN
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
`endif
        end
    end

    assign bus.hz_stall_o = hz_stall;
    assign bus.branch_o   = branch;
    assign bus.jump_o     = jump;
    assign bus.flush_o    = branch | jump;
    assign bus.ex_ctrl_o  = idex_q[3:0];
    assign bus.mem_ctrl_o = exmem_q[1:0];
    assign bus.wb_ctrl_o  = memwb_q;
    assign bus.illegal_o  = illegal_q;
    assign bus.ill_cnt_o  = ill_cnt_q;
`ifdef CTRL_PERF_CNT_EN
    assign bus.stall_cnt_o = stall_cnt_q;
    assign bus.flush_cnt_o = flush_cnt_q;
`endif
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
module tb_pipe_ctrl_unit;
  localparam logic [5:0] R   = 6'b000000;
  localparam logic [5:0] ADI = 6'b001000;
  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] SW  = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100;
  localparam logic [5:0] J   = 6'b000010;
  localparam logic [5:0] ILL = 6'b010101;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_ctrl_unit_if #(.REG_ADDR_W(5), .ILL_CNT_W(8)) bus ();
  pipe_ctrl_unit_if #(.REG_ADDR_W(5), .ILL_CNT_W(2)) bus2 ();

  pipe_ctrl_unit #(.REG_ADDR_W(5), .ILL_CNT_W(8)) u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .bus(bus.slave)
  );
  pipe_ctrl_unit #(.REG_ADDR_W(5), .ILL_CNT_W(2)) u_dut2 (
    .clk_i(clk), .rst_n_i(rst_n), .bus(bus2.slave)
  );

  // ---------------- vector table ----------------
  typedef struct {
    logic       v;
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       eq;
    logic       st;
    // expected: {hz, br, jp, fl, ex[3:0], mem[1:0], wb[1:0], ill}
    logic [12:0] exp;
    logic [7:0]  cnt;
  } vec_t;

  vec_t vecs[33];
  int n_vec = 0;
  int n_bad = 0;

  // ---------------- scoreboard ----------------
  logic [20:0] exp_q[$];

  function automatic logic [12:0] pack_out();
    return {bus.hz_stall_o, bus.branch_o, bus.jump_o, bus.flush_o,
            bus.ex_ctrl_o, bus.mem_ctrl_o, bus.wb_ctrl_o, bus.illegal_o};
  endfunction

  task automatic check_out(input string name, input logic [12:0] e, input logic [7:0] ec);
    logic [20:0] act;
    logic [20:0] want;
    exp_q.push_back({e, ec});
    want = exp_q.pop_front();
    act  = {pack_out(), bus.ill_cnt_o};
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got hz/br/jp/fl=%b ex=%h mem=%b wb=%b ill=%b cnt=%0d, want hz/br/jp/fl=%b ex=%h mem=%b wb=%b ill=%b cnt=%0d",
               name, act[20:17], act[16:13], act[12:11], act[10:9], act[8], act[7:0],
               want[20:17], want[16:13], want[12:11], want[10:9], want[8], want[7:0]);
    end
  endtask

  task automatic check_val(input string name, input int act, input int want);
    n_vec++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, want);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic v, input logic [5:0] op, input logic [4:0] rs,
                       input logic [4:0] rt, input logic eq, input logic st);
    bus.valid_i = v;  bus.op_i = op;  bus.rs_i = rs;  bus.rt_i = rt;
    bus.eq_i = eq;    bus.stall_i = st;
    bus2.valid_i = v; bus2.op_i = op; bus2.rs_i = rs; bus2.rt_i = rt;
    bus2.eq_i = eq;   bus2.stall_i = st;
  endtask

  function automatic vec_t mk(input logic v, input logic [5:0] op, input logic [4:0] rs,
                              input logic [4:0] rt, input logic eq, input logic st,
                              input logic [3:0] f, input logic [3:0] ex, input logic [1:0] mem,
                              input logic [1:0] wb, input logic ill, input logic [7:0] cnt);
    vec_t t;
    t.v = v; t.op = op; t.rs = rs; t.rt = rt; t.eq = eq; t.st = st;
    t.exp = {f, ex, mem, wb, ill};
    t.cnt = cnt;
    return t;
  endfunction

  initial begin
    // Each row is one cycle: inputs applied after a rising edge, outputs
    // expected before the next one. f = {hz, br, jp, fl}.
    //               v  op   rs  rt eq st  f       ex    mem  wb ill cnt
    vecs[0]  = mk(0, R,   0, 0, 0, 0, 4'b0000, 4'h0, 0, 0, 0, 0);  // idle after reset
    vecs[1]  = mk(0, R,   0, 0, 0, 0, 4'b0000, 4'h0, 0, 0, 0, 0);
    vecs[2]  = mk(0, R,   0, 0, 0, 0, 4'b0000, 4'h0, 0, 0, 0, 0);
    vecs[3]  = mk(1, LW,  1, 5, 0, 0, 4'b0000, 4'h0, 0, 0, 0, 0);  // lw rt=5
    vecs[4]  = mk(1, R,   5, 2, 0, 0, 4'b1000, 4'h1, 0, 0, 0, 0);  // load-use on rs
    vecs[5]  = mk(1, R,   5, 2, 0, 0, 4'b0000, 4'h0, 1, 0, 0, 0);  // R issues, bubble in EX
    vecs[6]  = mk(0, R,   0, 0, 0, 0, 4'b0000, 4'hE, 0, 1, 0, 0);
    vecs[7]  = mk(0, R,   0, 0, 0, 0, 4'b0000, 4'h0, 0, 0, 0, 0);
    vecs[8]  = mk(1, ADI, 0, 3, 0, 0, 4'b0000, 4'h0, 0, 3, 0, 0);  // addi
    vecs[9]  = mk(0, R,   0, 0, 0, 1, 4'b0000, 4'h1, 0, 0, 0, 0);  // 4 stall cycles
    vecs[10] = mk(0, R,   0, 0, 0, 1, 4'b0000, 4'h1, 0, 0, 0, 0);
    vecs[11] = mk(0, R,   0, 0, 0, 1, 4'b0000, 4'h1, 0, 0, 0, 0);
    vecs[12] = mk(0, R,   0, 0, 0, 1, 4'b0000, 4'h1, 0, 0, 0, 0);
    vecs[13] = mk(0, R,   0, 0, 0, 0, 4'b0000, 4'h1, 0, 0, 0, 0);  // released
    vecs[14] = mk(0, R,   0, 0, 0, 0, 4'b0000, 4'h0, 0, 0, 0, 0);
    vecs[15] = mk(1, BEQ, 1, 2, 1, 0, 4'b0101, 4'h0, 0, 3, 0, 0);  // beq taken
    vecs[16] = mk(1, BEQ, 1, 2, 0, 0, 4'b0000, 4'h0, 0, 0, 0, 0);  // beq not taken
    vecs[17] = mk(1, J,   0, 0, 0, 0, 4'b0011, 4'h0, 0, 0, 0, 0);  // jump
    vecs[18] = mk(1, ILL, 0, 0, 0, 0, 4'b0000, 4'h0, 0, 0, 0, 0);  // illegal x3
    vecs[19] = mk(1, ILL, 0, 0, 0, 0, 4'b0000, 4'h0, 0, 0, 1, 1);
    vecs[20] = mk(1, ILL, 0, 0, 0, 0, 4'b0000, 4'h0, 0, 0, 1, 2);
    vecs[21] = mk(0, R,   0, 0, 0, 0, 4'b0000, 4'h0, 0, 0, 1, 3);
    vecs[22] = mk(1, LW,  0, 0, 0, 0, 4'b0000, 4'h0, 0, 0, 1, 3);  // lw rt=0
    vecs[23] = mk(1, R,   0, 0, 0, 0, 4'b0000, 4'h1, 0, 0, 1, 3);  // no hazard on $0
    vecs[24] = mk(1, LW,  3, 7, 0, 0, 4'b0000, 4'hE, 1, 0, 1, 3);  // lw rt=7
    vecs[25] = mk(1, SW,  1, 7, 0, 0, 4'b1000, 4'h1, 0, 1, 1, 3);  // sw uses rt -> hazard
    vecs[26] = mk(1, LW,  0, 9, 0, 0, 4'b0000, 4'h0, 1, 3, 1, 3);  // lw rt=9 (sw dropped)
    vecs[27] = mk(1, ADI, 1, 9, 0, 0, 4'b0000, 4'h1, 0, 1, 1, 3);  // addi ignores rt
    vecs[28] = mk(1, LW,  0, 4, 0, 0, 4'b0000, 4'h1, 1, 0, 1, 3);  // lw rt=4
    vecs[29] = mk(1, BEQ, 4, 1, 1, 0, 4'b1000, 4'h1, 0, 1, 1, 3);  // hazard suppresses branch
    vecs[30] = mk(0, R,   0, 0, 0, 1, 4'b0000, 4'h0, 1, 3, 1, 3);  // stall holds
    vecs[31] = mk(0, R,   0, 0, 0, 0, 4'b0000, 4'h0, 1, 3, 1, 3);
    vecs[32] = mk(0, R,   0, 0, 0, 0, 4'b0000, 4'h0, 0, 1, 1, 3);

    drive(0, R, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 33; i++) begin
      drive(vecs[i].v, vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].eq, vecs[i].st);
      @(negedge clk);
      check_out($sformatf("vec%0d", i), vecs[i].exp, vecs[i].cnt);
      @(posedge clk);
      #1;
    end

`ifdef CTRL_PERF_CNT_EN
    check_val("stall_cnt", int'(bus.stall_cnt_o), 3);
    check_val("flush_cnt", int'(bus.flush_cnt_o), 2);
`endif

    // ---- reset mid-stream with lw in EX/MEM ----
    drive(1, LW, 0, 6, 0, 0);
    @(posedge clk); #1;
    drive(0, R, 0, 0, 0, 0);
    @(posedge clk); #1;
    check_val("lw_in_exmem_mem", int'(bus.mem_ctrl_o), 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_val("rst_mem", int'(bus.mem_ctrl_o), 0);
    check_val("rst_wb_ex", int'({bus.wb_ctrl_o, bus.ex_ctrl_o}), 0);
    check_val("rst_ill", int'({bus.illegal_o, bus.ill_cnt_o}), 0);
`ifdef CTRL_PERF_CNT_EN
    check_val("rst_perf", int'(bus.stall_cnt_o) + int'(bus.flush_cnt_o), 0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_val("post_rst_wb", int'(bus.wb_ctrl_o), 0);

    // ---- illegal counter saturation: 2-bit counter stops at 3 ----
    for (int k = 0; k < 5; k++) begin
      drive(1, ILL, 0, 0, 0, 0);
      @(posedge clk); #1;
    end
    drive(0, R, 0, 0, 0, 0);
    @(negedge clk);
    check_val("ill_cnt_w2_sat", int'(bus2.ill_cnt_o), 3);
    check_val("ill_cnt_w8", int'(bus.ill_cnt_o), 5);
    check_val("illegal_w2", int'(bus2.illegal_o), 1);
    check_val("no_wb_after_ill", int'({bus.wb_ctrl_o, bus.mem_ctrl_o, bus.ex_ctrl_o}), 0);

    // ---- illegal opcode under stall is not accepted ----
    @(posedge clk); #1;
    drive(1, ILL, 0, 0, 0, 1);
    @(posedge clk); #1;
    drive(0, R, 0, 0, 0, 0);
    @(negedge clk);
    check_val("ill_stalled_no_count", int'(bus.ill_cnt_o), 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, want finish");
    $fatal(1, "timeout");
  end
endmodule
